mem_stream_tester: RTL and testbench

Single-clock, parametrised successor of the feature/weight memory tester. It loads up to DEPTH words into a feature memory, then streams them through an internal synchronous FIFO into a weight memory. It then dumps the weight memory on port_d and, optionally, self-checks each dumped word against the feature memory. It sits between the host-side test port and the accelerator memories as a bring-up/BIST aid.

---
 rtl/mem_stream_pkg.sv | 10 +
 rtl/sync_fifo.sv | 45 ++++
 rtl/mem_stream_tester.sv | 111 +++++++++++
 tb/tb_mem_stream_tester.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_stream_pkg.sv
// mem_stream_pkg: state encoding and width helpers shared by the memory stream tester
package mem_stream_pkg;
    typedef enum logic [1:0] {IDLE, XFER, DUMP, DONE} state_e;
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction
    function automatic int ptr_w(input int fifo_depth);
        return $clog2(fifo_depth) + 1;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data and wrap-bit full/empty detection
module sync_fifo
    import mem_stream_pkg::*;
#(
    parameter int DW = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          winc,
    input  logic [DW-1:0] wdata,
    input  logic          rinc,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);
    localparam int PW = ptr_w(FIFO_DEPTH);
    localparam int AW = PW - 1;
    localparam logic [PW-1:0] ONE = PW'(1);
    logic [PW-1:0] wptr_q, rptr_q;
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] mem_q [FIFO_DEPTH];
    logic do_wr, do_rd;
    assign full = wptr_q[PW-1] != rptr_q[PW-1] && wptr_q[AW-1:0] == rptr_q[AW-1:0];
    assign empty = wptr_q == rptr_q;
    assign do_wr = winc && !full;
    assign do_rd = rinc && !empty;
    assign rdata = rdata_q;
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wptr_q[AW-1:0]] <= wdata;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            rdata_q <= '0;
        end else begin
            if (do_wr) wptr_q <= wptr_q + ONE;
            if (do_rd) begin
                rdata_q <= mem_q[rptr_q[AW-1:0]];
                rptr_q <= rptr_q + ONE;
            end
        end
    end
endmodule

// File: rtl/mem_stream_tester.sv
// mem_stream_tester: loads a feature memory, streams it through a FIFO into a weight memory, then dumps and self-checks it
module mem_stream_tester
    import mem_stream_pkg::*;
#(
    parameter int DW = 8,
    parameter int DEPTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter bit CHECK_EN = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DW-1:0]           port_a,
    input  logic                    w_en,
    input  logic                    start,
    input  logic                    r_en,
    output logic [DW-1:0]           port_d,
    output logic                    d_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    load_ovf,
    output logic [cnt_w(DEPTH)-1:0] err_cnt
);
    localparam int CW = cnt_w(DEPTH);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] ONE = CW'(1);
    state_e state_q;
    logic [CW-1:0] load_cnt_q, xfer_len_q, push_idx_q, wr_idx_q, dump_idx_q, err_q;
    logic signed [DW-1:0] feat_mem [DEPTH];
    logic signed [DW-1:0] wgt_mem [DEPTH];
    logic [DW-1:0] port_d_q, fifo_rdata;
    logic d_valid_q, load_ovf_q, pop_vld_q, fifo_full, fifo_empty;
    logic load_ok, load_we, push, pop, mismatch;
    assign load_ok = load_cnt_q < FULL;
    assign load_we = state_q == IDLE && w_en && load_ok;
    assign push = state_q == XFER && !fifo_full && push_idx_q < xfer_len_q;
    assign pop = state_q == XFER && !fifo_empty && r_en;
    assign mismatch = wgt_mem[dump_idx_q[AW-1:0]] != feat_mem[dump_idx_q[AW-1:0]];
    assign port_d = port_d_q;
    assign d_valid = d_valid_q;
    assign busy = state_q == XFER || state_q == DUMP;
    assign done = state_q == DONE;
    assign load_ovf = load_ovf_q;
    assign err_cnt = CHECK_EN ? err_q : '0;
    sync_fifo #(.DW(DW), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .winc  (push),
        .wdata (feat_mem[push_idx_q[AW-1:0]]),
        .rinc  (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
    always_ff @(posedge clk) begin
        if (load_we) feat_mem[load_cnt_q[AW-1:0]] <= port_a;
        if (pop_vld_q) wgt_mem[wr_idx_q[AW-1:0]] <= fifo_rdata;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            load_cnt_q <= '0;
            xfer_len_q <= '0;
            push_idx_q <= '0;
            wr_idx_q <= '0;
            dump_idx_q <= '0;
            err_q <= '0;
            port_d_q <= '0;
            d_valid_q <= 1'b0;
            load_ovf_q <= 1'b0;
            pop_vld_q <= 1'b0;
        end else begin
            pop_vld_q <= pop;
            if (pop_vld_q) wr_idx_q <= wr_idx_q + ONE;
            if (push) push_idx_q <= push_idx_q + ONE;
            case (state_q)
                IDLE: begin
                    if (load_we) load_cnt_q <= load_cnt_q + ONE;
                    if (w_en && !load_ok) load_ovf_q <= 1'b1;
                    // a word written in the start cycle is part of the transfer
                    if (start && (load_cnt_q != '0 || load_we)) begin
                        state_q <= XFER;
                        xfer_len_q <= load_cnt_q + (load_we ? ONE : '0);
                        push_idx_q <= '0;
                        wr_idx_q <= '0;
                        dump_idx_q <= '0;
                        err_q <= '0;
                    end
                end
                XFER: if (wr_idx_q == xfer_len_q) state_q <= DUMP;
                DUMP: begin
                    if (dump_idx_q == xfer_len_q) begin
                        state_q <= DONE;
                        d_valid_q <= 1'b0;
                    end else begin
                        d_valid_q <= r_en;
                        if (r_en) begin
                            port_d_q <= wgt_mem[dump_idx_q[AW-1:0]];
                            dump_idx_q <= dump_idx_q + ONE;
                            if (CHECK_EN && mismatch && err_q != FULL) err_q <= err_q + ONE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    load_cnt_q <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stream_tester.sv
// tb_mem_stream_tester: directed bench checking both CHECK_EN builds against a queue model of load/transfer/dump
module tb_mem_stream_tester;
    import mem_stream_pkg::*;
    localparam int DW = 8;
    localparam int DEPTH = 16;
    localparam int CW = 5;
    logic clk = 1'b0, rst_n = 1'b0, w_en = 1'b0, start = 1'b0, r_en = 1'b0;
    logic [DW-1:0] port_a = '0;
    logic [DW-1:0] port_d0, port_d1;
    logic d_valid0, d_valid1, busy0, busy1, done0, done1, ovf0, ovf1;
    logic [CW-1:0] err0, err1;
    int n_vec = 0, n_bad = 0;
    bit chk_on = 1'b0;
    logic [DW-1:0] m_feat [DEPTH];
    int m_load = 0;
    bit m_ovf = 1'b0;
    logic [DW-1:0] exp_q [$];
    int exp_err = 0, done_cnt = 0, n_words = 0;
    logic [DW-1:0] first_word = '0, last_word = '0;

    always #5 clk = ~clk;

    mem_stream_tester #(.DW(DW), .DEPTH(DEPTH), .FIFO_DEPTH(4), .CHECK_EN(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .port_a(port_a), .w_en(w_en), .start(start), .r_en(r_en),
        .port_d(port_d0), .d_valid(d_valid0), .busy(busy0), .done(done0), .load_ovf(ovf0), .err_cnt(err0));
    mem_stream_tester #(.DW(DW), .DEPTH(DEPTH), .FIFO_DEPTH(4), .CHECK_EN(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .port_a(port_a), .w_en(w_en), .start(start), .r_en(r_en),
        .port_d(port_d1), .d_valid(d_valid1), .busy(busy1), .done(done1), .load_ovf(ovf1), .err_cnt(err1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("load_ovf", 32'(ovf0), 32'(m_ovf));
            check("load_ovf_nochk", 32'(ovf1), 32'(m_ovf));
            if (d_valid0) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", 32'(port_d0), 32'hFFFF_FFFF);
                end else begin
                    logic [DW-1:0] w;
                    w = exp_q.pop_front();
                    check("port_d", 32'(port_d0), 32'(w));
                    check("d_valid_nochk", 32'(d_valid1), 32'd1);
                    check("port_d_nochk", 32'(port_d1), 32'(w));
                    if (n_words == 0) first_word = port_d0;
                    last_word = port_d0;
                    n_words++;
                end
            end
            if (done0) begin
                done_cnt++;
                check("words_left_at_done", 32'(exp_q.size()), 32'd0);
                check("err_cnt", 32'(err0), 32'(exp_err));
                check("err_cnt_nochk", 32'(err1), 32'd0);
                check("busy_at_done", 32'(busy0), 32'd0);
                check("done_nochk", 32'(done1), 32'd1);
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_load = 0;
        m_ovf = 1'b0;
        exp_q.delete();
        chk_on = 1'b1;
        check("rst_state", 32'(dut0.state_q), 32'(IDLE));
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_d_valid", 32'(d_valid0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_port_d", 32'(port_d0), 32'd0);
        check("rst_err", 32'(err0), 32'd0);
        check("rst_ovf", 32'(ovf0), 32'd0);
        check("rst_fifo_empty", 32'(dut0.u_fifo.empty), 32'd1);
    endtask

    task automatic load(input logic [DW-1:0] v);
        w_en = 1'b1;
        port_a = v;
        tick();
        w_en = 1'b0;
        if (m_load < DEPTH) begin
            m_feat[m_load] = v;
            m_load++;
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic load_seq(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) load(base + DW'(i));
    endtask

    task automatic run(input bit toggle, input bit poke, input bit sid, input int exp_len);
        int cyc = 0;
        int d0 = done_cnt;
        bit poked = 1'b0, restarted = 1'b0;
        exp_q.delete();
        for (int i = 0; i < m_load; i++) exp_q.push_back((poke && i == 3) ? 8'h7F : m_feat[i]);
        exp_err = 0;
        for (int i = 0; i < m_load; i++) if (exp_q[i] != m_feat[i]) exp_err++;
        check("model_len", 32'(exp_q.size()), 32'(exp_len));
        n_words = 0;
        r_en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", 32'(busy0), 32'd1);
        while (done_cnt == d0 && cyc < 400) begin
            start = 1'b0;
            if (toggle) r_en = ~r_en;
            if (dut0.state_q == DUMP) begin
                if (poke && !poked) begin
                    dut0.wgt_mem[3] = 8'h7F;
                    dut1.wgt_mem[3] = 8'h7F;
                    poked = 1'b1;
                end
                if (sid && !restarted) begin
                    start = 1'b1;
                    restarted = 1'b1;
                end
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        r_en = 1'b1;
        check("run_timeout", 32'(cyc < 400), 32'd1);
        tick();
        tick();
        check("single_done", 32'(done_cnt - d0), 32'd1);
        check("busy_after_done", 32'(busy0), 32'd0);
        m_load = 0;
    endtask

    initial begin
        int d0;
        do_reset();
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("empty_start_busy", 32'(busy0), 32'd0);
        check("empty_start_state", 32'(dut0.state_q), 32'(IDLE));
        check("empty_start_done", 32'(done_cnt - d0), 32'd0);

        load_seq(8'h01, 16);
        run(1'b0, 1'b0, 1'b0, 16);
        check("pin_words_16", 32'(n_words), 32'd16);
        check("pin_first_01", 32'(first_word), 32'h01);
        check("pin_last_10", 32'(last_word), 32'h10);
        check("pin_err_0", 32'(err0), 32'd0);

        load_seq(8'h21, 5);
        run(1'b0, 1'b0, 1'b1, 5);
        check("pin_words_5", 32'(n_words), 32'd5);
        check("pin_last_25", 32'(last_word), 32'h25);

        load_seq(8'h01, 16);
        load(8'hEE);
        check("pin_ovf_set", 32'(ovf0), 32'd1);
        check("pin_feat15_kept", 32'(dut0.feat_mem[15]), 32'h10);
        run(1'b1, 1'b0, 1'b0, 16);
        check("pin_toggle_words", 32'(n_words), 32'd16);
        check("pin_toggle_last", 32'(last_word), 32'h10);

        load_seq(8'h01, 16);
        run(1'b0, 1'b1, 1'b0, 16);
        check("pin_poke_err", 32'(err0), 32'd1);
        check("pin_poke_err_nochk", 32'(err1), 32'd0);

        load_seq(8'h01, 16);
        r_en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("pin_pushes_7", 32'(dut0.push_idx_q), 32'd7);
        do_reset();
        load_seq(8'hA0, 4);
        run(1'b0, 1'b0, 1'b0, 4);
        check("pin_fresh_words", 32'(n_words), 32'd4);
        check("pin_fresh_first", 32'(first_word), 32'hA0);
        check("pin_fresh_last", 32'(last_word), 32'hA3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
